// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: instruction constants, the fetch
// halt-FSM state type and the IF/ID pipeline record consumed by decode.
package core_pkg;

   localparam int CORE_XLEN = 32;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic                 valid;
      logic [CORE_XLEN-1:0] pc;
      logic [31:0]          instr;
   } if_id_t;

   // True for the two environment-call words that stop the core.
   function automatic logic is_halt_instr(input logic [31:0] instr);
      return (instr == ECALL_INSTR) || (instr == EBREAK_INSTR);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble has priority over load; with neither
// asserted the register holds (stall). Reset leaves a bubble.
module if_id_reg
   import core_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 bubble,
   input  logic [CORE_XLEN-1:0] d_pc,
   input  logic [31:0]          d_instr,
   output logic                 q_valid,
   output logic [CORE_XLEN-1:0] q_pc,
   output logic [31:0]          q_instr
);

   localparam if_id_t BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

   if_id_t ifid_reg;

   // Load, squash or hold the IF/ID record.
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         ifid_reg <= BUBBLE;
      end else if (load) begin
         ifid_reg <= '{valid: 1'b1, pc: d_pc, instr: d_instr};
      end
   end

   assign q_valid = ifid_reg.valid;
   assign q_pc    = ifid_reg.pc;
   assign q_instr = ifid_reg.instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register control and the
// RUN/DRAIN/HALT FSM that drains the pipeline after ECALL/EBREAK.
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters for
// fetched instructions, stall-hold cycles and redirect edges.
// The IF/ID record is sized by CORE_XLEN, so XLEN is expected to match it.
module fetch_stage
   import core_pkg::*;
#(
   parameter int                 XLEN         = CORE_XLEN,
   parameter logic [XLEN-1:0]    RESET_PC     = '0,
   parameter int                 DRAIN_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [31:0]     imem_rdata_i,
   output logic            if_id_valid_o,
   output logic [XLEN-1:0] if_id_pc_o,
   output logic [31:0]     if_id_instr_o,
   output logic [XLEN-1:0] PC_out,
   output logic            halted_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched_o,
   output logic [31:0]     perf_stall_o,
   output logic [31:0]     perf_flush_o
`endif
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   fetch_state_t     state_reg, state_next;
   logic [XLEN-1:0]  pc_reg, pc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             halted_reg;
   logic             ifid_load, ifid_bubble;
   logic [XLEN-1:0]  redirect_target;

   // Instructions are word aligned; the low target bits are discarded.
   assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};

   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   // Next-state, next-PC and IF/ID control; redirect beats stall.
   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      cnt_next    = cnt_reg;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      case (state_reg)
         RUN: begin
            if (redirect_valid_i) begin
               pc_next     = redirect_target;
               ifid_bubble = 1'b1;
            end else if (!stall_i) begin
               ifid_load = 1'b1;
               if (is_halt_instr(imem_rdata_i)) begin
                  // Park the PC on the ECALL so nothing past it is fetched.
                  state_next = DRAIN;
                  cnt_next   = '0;
               end else begin
                  pc_next = pc_reg + XLEN'(4);
               end
            end
         end
         DRAIN: begin
            if (redirect_valid_i) begin
               // The ECALL was on the wrong path; resume fetching.
               state_next  = RUN;
               cnt_next    = '0;
               pc_next     = redirect_target;
               ifid_bubble = 1'b1;
            end else if (!stall_i) begin
               ifid_bubble = 1'b1;
               if (cnt_reg == CNT_LAST) begin
                  state_next = HALT;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         HALT: begin
            ifid_bubble = 1'b1;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   // PC, FSM state, drain counter and the registered halt flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= RUN;
         pc_reg     <= RESET_PC;
         cnt_reg    <= '0;
         halted_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         cnt_reg    <= cnt_next;
         halted_reg <= (state_next == HALT);
      end
   end

   if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (ifid_load),
      .bubble  (ifid_bubble),
      .d_pc    (pc_reg),
      .d_instr (imem_rdata_i),
      .q_valid (if_id_valid_o),
      .q_pc    (if_id_pc_o),
      .q_instr (if_id_instr_o)
   );

   assign imem_addr_o = pc_reg;
   assign PC_out      = pc_reg;
   assign halted_o    = halted_reg;

`ifdef FETCH_PERF_CNT_EN
   // Event 0: valid IF/ID load, 1: stall-hold cycle, 2: redirect edge.
   logic [2:0] perf_evt;
   assign perf_evt[0] = ifid_load;
   assign perf_evt[1] = stall_i & ~redirect_valid_i;
   assign perf_evt[2] = redirect_valid_i;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_perf
         logic [31:0] cnt_reg;
         // Saturating event counter, frozen once the core has halted.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if ((state_reg != HALT) && perf_evt[gi] && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + 32'd1;
            end
         end
      end
   endgenerate

   assign perf_fetched_o = g_perf[0].cnt_reg;
   assign perf_stall_o   = g_perf[1].cnt_reg;
   assign perf_flush_o   = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run, all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam int          NDRAIN = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        if_id_valid_o;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_instr_o;
   logic [31:0] PC_out;
   logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_o, perf_stall_o, perf_flush_o;
   logic [31:0] m_pf, m_ps, m_pr;
`endif

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: architectural view of the stage.
   logic [31:0] m_pc, m_ipc, m_ins;
   logic        m_v, m_draining, m_halted;
   int          m_left;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_addr_o      (imem_addr_o),
      .imem_rdata_i     (imem_rdata_i),
      .if_id_valid_o    (if_id_valid_o),
      .if_id_pc_o       (if_id_pc_o),
      .if_id_instr_o    (if_id_instr_o),
      .PC_out           (PC_out),
      .halted_o         (halted_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o   (perf_fetched_o),
      .perf_stall_o     (perf_stall_o),
      .perf_flush_o     (perf_flush_o)
`endif
   );

   // addi x1,x1,imm with the immediate taken from the address.
   function automatic logic [31:0] addi_at(input logic [31:0] a);
      logic [11:0] imm;
      imm = a[13:2];
      return {imm, 5'd1, 3'b000, 5'd1, 7'h13};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   task automatic bubble_model();
      m_v = 1'b0; m_ipc = 32'h0; m_ins = NOP;
   endtask

   // Drive one cycle of inputs, clock it, and advance the model.
   task automatic tick(input logic r, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] w);
      rst = r; stall_i = st; redirect_valid_i = rv; redirect_pc_i = rpc; imem_rdata_i = w;
      @(posedge clk);
      if (r) begin
         m_pc = 32'h0; bubble_model(); m_draining = 1'b0; m_left = 0; m_halted = 1'b0;
`ifdef FETCH_PERF_CNT_EN
         m_pf = 0; m_ps = 0; m_pr = 0;
`endif
      end else if (m_halted) begin
         bubble_model();
      end else if (rv) begin
         m_pc = rpc & ~32'd3; bubble_model(); m_draining = 1'b0;
`ifdef FETCH_PERF_CNT_EN
         m_pr = sat_inc(m_pr);
`endif
      end else if (st) begin
`ifdef FETCH_PERF_CNT_EN
         m_ps = sat_inc(m_ps);
`endif
      end else if (m_draining) begin
         bubble_model();
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_halted = 1'b1; m_draining = 1'b0;
         end
      end else begin
         m_v = 1'b1; m_ipc = m_pc; m_ins = w;
`ifdef FETCH_PERF_CNT_EN
         m_pf = sat_inc(m_pf);
`endif
         if (w == ECALL || w == EBREAK) begin
            m_draining = 1'b1; m_left = NDRAIN;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(1'b1, 1'b1, 1'b1, 32'h1234, ECALL);
      vectors++; if (PC_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", PC_out, 32'h0); end
      vectors++; if (if_id_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", if_id_valid_o); end
      vectors++; if (if_id_pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_ifpc: got %h want 0", if_id_pc_o); end
      vectors++; if (if_id_instr_o !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h want %h", if_id_instr_o, NOP); end
      vectors++; if (halted_o !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted_o); end
      $display("reset: pc=%h valid=%b halted=%b", PC_out, if_id_valid_o, halted_o);
   endtask

   task automatic test_advance();
      logic [31:0] exp_pc;
      tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, addi_at(m_pc));
         exp_pc = 32'(4 * k);
         vectors++; if (PC_out !== exp_pc) begin miscompares++; $display("FAIL adv_pc: got %h want %h", PC_out, exp_pc); end
         vectors++; if (imem_addr_o !== exp_pc) begin miscompares++; $display("FAIL adv_addr: got %h want %h", imem_addr_o, exp_pc); end
         vectors++; if (if_id_pc_o !== exp_pc - 32'd4 || if_id_valid_o !== 1'b1) begin miscompares++; $display("FAIL adv_ifid: got pc %h v %b want pc %h v 1", if_id_pc_o, if_id_valid_o, exp_pc - 32'd4); end
         vectors++; if (if_id_instr_o !== addi_at(exp_pc - 32'd4)) begin miscompares++; $display("FAIL adv_instr: got %h want %h", if_id_instr_o, addi_at(exp_pc - 32'd4)); end
         $display("advance: pc=%h ifid_pc=%h instr=%h", PC_out, if_id_pc_o, if_id_instr_o);
      end
   endtask

   task automatic test_stall();
      tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 32'h0, addi_at(32'h0));
      tick(1'b0, 1'b0, 1'b0, 32'h0, addi_at(32'h4));
      for (int k = 0; k < 2; k++) begin
         tick(1'b0, 1'b1, 1'b0, 32'h0, addi_at(32'h8));
         vectors++; if (PC_out !== 32'h8) begin miscompares++; $display("FAIL stall_pc: got %h want 00000008", PC_out); end
         vectors++; if (if_id_pc_o !== 32'h4 || if_id_instr_o !== addi_at(32'h4) || if_id_valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_ifid: got %h/%h/%b want 00000004/%h/1", if_id_pc_o, if_id_instr_o, if_id_valid_o, addi_at(32'h4)); end
         $display("stall: pc=%h ifid_pc=%h", PC_out, if_id_pc_o);
      end
      tick(1'b0, 1'b0, 1'b0, 32'h0, addi_at(32'h8));
      vectors++; if (PC_out !== 32'hC || if_id_pc_o !== 32'h8) begin miscompares++; $display("FAIL stall_resume: got pc %h ifid %h want 0000000c 00000008", PC_out, if_id_pc_o); end
      $display("resume: pc=%h ifid_pc=%h", PC_out, if_id_pc_o);
   endtask

   task automatic test_redirect_stall();
      tick(1'b0, 1'b1, 1'b1, 32'h0000_0042, addi_at(m_pc));
      vectors++; if (PC_out !== 32'h40) begin miscompares++; $display("FAIL redir_pc: got %h want 00000040", PC_out); end
      vectors++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || if_id_pc_o !== 32'h0) begin miscompares++; $display("FAIL redir_bubble: got %b/%h/%h want 0/%h/0", if_id_valid_o, if_id_instr_o, if_id_pc_o, NOP); end
      $display("redirect+stall: pc=%h valid=%b instr=%h", PC_out, if_id_valid_o, if_id_instr_o);
   endtask

   task automatic test_ecall_halt();
      tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 32'h0, addi_at(m_pc));
      tick(1'b0, 1'b0, 1'b0, 32'h0, ECALL);
      vectors++; if (if_id_instr_o !== ECALL || if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h10) begin miscompares++; $display("FAIL ecall_latch: got %h/%b/%h want %h/1/00000010", if_id_instr_o, if_id_valid_o, if_id_pc_o, ECALL); end
      vectors++; if (PC_out !== 32'h10) begin miscompares++; $display("FAIL ecall_pc: got %h want 00000010", PC_out); end
      for (int k = 1; k <= NDRAIN; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, ECALL);
         vectors++; if (if_id_valid_o !== 1'b0 || PC_out !== 32'h10) begin miscompares++; $display("FAIL drain_bubble: got v %b pc %h want 0 00000010", if_id_valid_o, PC_out); end
         vectors++; if (halted_o !== (k == NDRAIN)) begin miscompares++; $display("FAIL drain_halted: cycle %0d got %b want %b", k, halted_o, (k == NDRAIN)); end
         $display("drain %0d: valid=%b halted=%b", k, if_id_valid_o, halted_o);
      end
      tick(1'b0, 1'b0, 1'b1, 32'h0000_0200, ECALL);
      vectors++; if (PC_out !== 32'h10 || halted_o !== 1'b1 || if_id_valid_o !== 1'b0) begin miscompares++; $display("FAIL halt_ignore: got pc %h h %b v %b want 00000010 1 0", PC_out, halted_o, if_id_valid_o); end
      $display("halted, redirect ignored: pc=%h halted=%b", PC_out, halted_o);
   endtask

   task automatic test_drain_redirect();
      tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 32'h0, addi_at(32'h0));
      tick(1'b0, 1'b0, 1'b0, 32'h0, EBREAK);
      tick(1'b0, 1'b0, 1'b0, 32'h0, EBREAK);
      tick(1'b0, 1'b0, 1'b1, 32'h0000_0080, EBREAK);
      vectors++; if (PC_out !== 32'h80 || if_id_valid_o !== 1'b0) begin miscompares++; $display("FAIL drain_redir: got pc %h v %b want 00000080 0", PC_out, if_id_valid_o); end
      for (int k = 0; k < 8; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0, addi_at(m_pc));
         vectors++; if (halted_o !== 1'b0 || PC_out !== m_pc) begin miscompares++; $display("FAIL after_redir: got pc %h h %b want %h 0", PC_out, halted_o, m_pc); end
      end
      $display("drain redirected: pc=%h halted=%b", PC_out, halted_o);
      tick(1'b0, 1'b0, 1'b0, 32'h0, ECALL);
      for (int k = 0; k < NDRAIN; k++) tick(1'b0, 1'b0, 1'b0, 32'h0, ECALL);
      vectors++; if (halted_o !== 1'b1) begin miscompares++; $display("FAIL second_halt: got %b want 1", halted_o); end
      tick(1'b1, 1'b0, 1'b0, 32'h0, ECALL);
      vectors++; if (PC_out !== 32'h0 || halted_o !== 1'b0 || if_id_valid_o !== 1'b0) begin miscompares++; $display("FAIL halt_reset: got pc %h h %b v %b want 0 0 0", PC_out, halted_o, if_id_valid_o); end
      $display("reset from halt: pc=%h halted=%b", PC_out, halted_o);
   endtask

   task automatic test_wrap();
      tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, addi_at(32'h0));
      tick(1'b0, 1'b0, 1'b0, 32'h0, addi_at(32'hFFFF_FFFC));
      vectors++; if (PC_out !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want 00000000", PC_out); end
      vectors++; if (if_id_pc_o !== 32'hFFFF_FFFC || if_id_valid_o !== 1'b1) begin miscompares++; $display("FAIL wrap_ifid: got %h v %b want fffffffc 1", if_id_pc_o, if_id_valid_o); end
`ifdef FETCH_PERF_CNT_EN
      vectors++; if (perf_flush_o !== 32'd1 || perf_fetched_o !== 32'd1) begin miscompares++; $display("FAIL wrap_perf: got flush %0d fetched %0d want 1 1", perf_flush_o, perf_fetched_o); end
`endif
      $display("wrap: pc=%h ifid_pc=%h", PC_out, if_id_pc_o);
   endtask

   task automatic test_random();
      logic r, st, rv;
      logic [31:0] rpc, w;
      int sel;
      tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int n = 0; n < 400; n++) begin
         r   = ($urandom_range(0, 99) == 0);
         st  = ($urandom_range(0, 99) < 25);
         rv  = ($urandom_range(0, 99) < 6);
         rpc = $urandom;
         sel = $urandom_range(0, 99);
         if (sel < 3) w = ECALL;
         else if (sel < 5) w = EBREAK;
         else begin
            w = $urandom;
            if (w == ECALL || w == EBREAK) w = NOP;
         end
         tick(r, st, rv, rpc, w);
         vectors++;
         if (PC_out !== m_pc || imem_addr_o !== m_pc || if_id_valid_o !== m_v ||
             if_id_pc_o !== m_ipc || if_id_instr_o !== m_ins || halted_o !== m_halted) begin
            miscompares++;
            $display("FAIL rand[%0d]: got pc %h addr %h v %b ipc %h ins %h h %b want pc %h v %b ipc %h ins %h h %b",
                     n, PC_out, imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_instr_o, halted_o,
                     m_pc, m_v, m_ipc, m_ins, m_halted);
         end
`ifdef FETCH_PERF_CNT_EN
         vectors++;
         if (perf_fetched_o !== m_pf || perf_stall_o !== m_ps || perf_flush_o !== m_pr) begin
            miscompares++;
            $display("FAIL rand_perf[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", n,
                     perf_fetched_o, perf_stall_o, perf_flush_o, m_pf, m_ps, m_pr);
         end
`endif
         $display("rand %0d: rst=%b st=%b rv=%b pc=%h v=%b halted=%b", n, r, st, rv, PC_out, if_id_valid_o, halted_o);
      end
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0;
      redirect_pc_i = 32'h0; imem_rdata_i = NOP;
      test_reset();
      test_advance();
      test_stall();
      test_redirect_stall();
      test_ecall_halt();
      test_drain_redirect();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
